divider_32bit_seq: RTL and testbench

Iterative 32-bit unsigned restoring divider. Sequences one shared 32-bit subtract datapath over 32 clock cycles, one quotient bit per cycle. Sits beside the combinational adder/subtractor blocks in the ALU as the multi-cycle divide unit. Talks to the issuing logic through a start/busy/done handshake.

---
 rtl/divider_32bit_seq.sv | 95 +++++++++
 tb/tb_divider_32bit_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_32bit_seq.sv
// Iterative 32-bit unsigned restoring divider: one quotient bit per clock over
// 32 cycles, driven through a start/busy/done handshake with synchronous abort.
module divider_32bit_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] part_rem;
  logic [31:0] quo_shift;
  logic [31:0] dvsr;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] next_rem;
  logic [31:0] next_quo;

  // One shared subtractor: its borrow-out doubles as the S[31:0] >= D compare,
  // and when S[32] is set the low 32 bits of the difference are already exact.
  always_comb begin
    shifted  = {part_rem, quo_shift[31]};
    diff     = {1'b0, shifted[31:0]} - {1'b0, dvsr};
    ge       = shifted[32] | ~diff[32];
    next_rem = ge ? diff[31:0] : shifted[31:0];
    next_quo = {quo_shift[30:0], ge};
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      part_rem    <= 32'd0;
      quo_shift   <= 32'd0;
      dvsr        <= 32'd0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (divisor != 32'd0) begin
              quo_shift   <= dividend;
              part_rem    <= 32'd0;
              dvsr        <= divisor;
              cnt         <= 5'd0;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end else begin
              quotient    <= 32'hFFFF_FFFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            part_rem  <= next_rem;
            quo_shift <= next_quo;
            cnt       <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              quotient  <= next_quo;
              remainder <= next_rem;
              state     <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32bit_seq.sv
// Bench for divider_32bit_seq: directed vector table, handshake corner cases
// (ignored start, abort, mid-run reset) and random operands against a / and % model.
module tb_divider_32bit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  divider_32bit_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Starts one divide and waits (bounded) for done. Latency is counted in edges
  // after the accepting edge; busy_cyc counts sampled cycles with busy high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int ignore_at,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat, output int busy_cyc);
    bit seen = 0;
    int k = 0;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) busy_cyc++;
      if (done) begin seen = 1; break; end
      @(negedge clk);
      k++;
      start = (k == ignore_at);
      if (start) begin dividend = 32'd50; divisor = 32'd5; end
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: done not seen for %h / %h", a, b);
    end
    q = quotient; r = remainder; dz = div_by_zero; lat = k;
    @(negedge clk);
    check("done_falls", {31'd0, done}, 32'd0);
    check("busy_falls", {31'd0, busy}, 32'd0);
  endtask

  task automatic watch_no_done(input int cycles, input string name);
    bit saw = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    check(name, {31'd0, saw}, 32'd0);
  endtask

  vec_t        tbl[7];
  logic [31:0] q, r, eq, er, a, b;
  logic        dz;
  int          lat, bc;

  initial begin
    tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32};
    tbl[1] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 32};
    tbl[2] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32};
    tbl[3] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 32};
    tbl[4] = '{32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 32};
    tbl[5] = '{32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0};
    tbl[6] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, -1, q, r, dz, lat, bc);
      check("vec_quotient", q, tbl[i].q);
      check("vec_remainder", r, tbl[i].r);
      check("vec_dz", {31'd0, dz}, {31'd0, tbl[i].dz});
      check("vec_latency", lat, tbl[i].lat);
      check("vec_busy_cycles", bc, tbl[i].lat + 1);
    end

    // A start pulse in the middle of a divide must be ignored.
    run_op(32'd100, 32'd7, 10, q, r, dz, lat, bc);
    check("ignore_quotient", q, 32'd14);
    check("ignore_remainder", r, 32'd2);
    check("ignore_latency", lat, 32);
    watch_no_done(5, "ignore_no_extra_done");

    // Abort at cycle 10: back to IDLE, no done, previous results kept.
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    watch_no_done(40, "abort_no_done");
    check("abort_quotient", quotient, 32'd14);
    check("abort_remainder", remainder, 32'd2);

    // Abort together with start in IDLE drops the start.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    watch_no_done(40, "idle_abort_no_done");

    // Asynchronous reset at cycle 15 of a divide.
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done(40, "midrst_no_done");
    run_op(32'd9, 32'd3, -1, q, r, dz, lat, bc);
    check("post_rst_quotient", q, 32'd3);
    check("post_rst_remainder", r, 32'd0);
    check("post_rst_latency", lat, 32);

    // Random operands against plain arithmetic.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = (i % 8 == 3) ? 32'd0 : ($urandom | 32'h8000_0000);
      endcase
      if (b == 32'd0) begin eq = 32'hFFFF_FFFF; er = a; end
      else begin eq = a / b; er = a % b; end
      run_op(a, b, -1, q, r, dz, lat, bc);
      check("rand_quotient", q, eq);
      check("rand_remainder", r, er);
      check("rand_dz", {31'd0, dz}, {31'd0, (b == 32'd0)});
      check("rand_latency", lat, (b == 32'd0) ? 0 : 32);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
